// File: rtl/serial_tx_pkg.sv
// Shared constants for the serial link: state encoding and frame geometry
// used by the 8N1 transmitter.
package serial_tx_pkg;

  localparam int unsigned STATE_SIZE   = 2;
  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned BIT_IDX_SIZE = $clog2(DATA_BITS);

  typedef enum logic [STATE_SIZE-1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA      = 2'd2,
    STOP_BIT  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/serial_tx.sv
// UART transmitter, 8N1, LSB first.
// Ports:
//   clk      - system clock, posedge
//   rst      - synchronous reset, active-high
//   block    - 1 = do not start a new frame (registered once internally)
//   data     - byte to send, sampled on an accepted new_data
//   new_data - single-cycle strobe, accepted only while busy = 0
//   busy     - 1 = new_data is ignored this cycle
//   tx       - serial line, idles high
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       block,
  input  logic [7:0] data,
  input  logic       new_data,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned CTR_SIZE = $clog2(CLK_PER_BIT);
  localparam logic [CTR_SIZE-1:0]     CTR_LAST = CTR_SIZE'(CLK_PER_BIT - 1);
  localparam logic [BIT_IDX_SIZE-1:0] BIT_LAST = BIT_IDX_SIZE'(DATA_BITS - 1);

  tx_state_e               state_q, state_d;
  logic [CTR_SIZE-1:0]     ctr_q, ctr_d;
  logic [BIT_IDX_SIZE-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0]    shift_q, shift_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    block_q;

  assign tx   = tx_q;
  assign busy = busy_q;

  // Next-state, bit timing and line value.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    case (state_q)
      IDLE: begin
        if (new_data && !busy_q) begin
          shift_d = data;
          ctr_d   = '0;
          state_d = START_BIT;
        end
      end
      START_BIT: begin
        ctr_d = ctr_q + CTR_SIZE'(1);
        if (ctr_q == CTR_LAST) begin
          ctr_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        ctr_d = ctr_q + CTR_SIZE'(1);
        if (ctr_q == CTR_LAST) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_IDX_SIZE'(1);
          ctr_d   = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP_BIT;
          end
        end
      end
      STOP_BIT: begin
        ctr_d = ctr_q + CTR_SIZE'(1);
        if (ctr_q == CTR_LAST) begin
          ctr_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line value follows the upcoming state so the registered tx lines up
    // with the state it belongs to: start bit appears the cycle after accept.
    case (state_d)
      START_BIT: tx_d = 1'b0;
      DATA:      tx_d = shift_d[0];
      default:   tx_d = 1'b1;
    endcase

    // Registered form of (state != IDLE) | block_q, built from next values.
    busy_d = (state_d != IDLE) | block;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b1;
      block_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      block_q <= block;
    end
  end

  // block_q is kept as the architectural register behind busy.
  logic unused_block_q;
  assign unused_block_q = block_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx with CLK_PER_BIT = 4.
module tb_serial_tx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       block = 1'b0;
  logic [7:0] data = 8'h00;
  logic       new_data = 1'b0;
  logic       busy;
  logic       tx;

  int n_cmp = 0;
  int n_err = 0;

  serial_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .block    (block),
    .data     (data),
    .new_data (new_data),
    .busy     (busy),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send byte b and check every line cycle of its frame; a dropped strobe
  // and/or a block assertion may be injected at frame cycle drop_at/block_at.
  task automatic frame(input logic [7:0] b, input int drop_at, input int block_at);
    logic [9:0] bits;
    logic [7:0] rx;
    bits = {1'b1, b, 1'b0};
    rx   = 8'h00;
    data = b;
    new_data = 1'b1;
    step();
    new_data = 1'b0;
    for (int k = 0; k < 10 * CPB; k++) begin
      chk($sformatf("tx_%02h_k%0d", b, k), 32'(tx), 32'(bits[k / CPB]));
      chk($sformatf("busy_%02h_k%0d", b, k), 32'(busy), 32'(1));
      if ((k % CPB) == 2 && k >= CPB && k < 9 * CPB) rx[3'((k - CPB) / CPB)] = tx;
      if (k == drop_at) begin
        data = 8'h3C;
        new_data = 1'b1;
      end else begin
        new_data = 1'b0;
      end
      if (k == block_at) block = 1'b1;
      step();
    end
    new_data = 1'b0;
    chk($sformatf("rx_byte_%02h", b), 32'(rx), 32'(b));
  endtask

  initial begin
    logic [9:0] bits96;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_tx_%0d", i), 32'(tx), 32'(1));
      chk($sformatf("rst_busy_%0d", i), 32'(busy), 32'(1));
    end
    rst = 1'b0;
    step();
    step();
    chk("post_rst_busy", 32'(busy), 32'(0));
    chk("post_rst_tx", 32'(tx), 32'(1));

    // Single byte
    frame(8'hA5, -1, -1);
    chk("a5_end_busy", 32'(busy), 32'(0));
    chk("a5_end_tx", 32'(tx), 32'(1));

    // Back-to-back on first busy = 0 cycle
    frame(8'h00, -1, -1);
    chk("b2b_busy", 32'(busy), 32'(0));
    frame(8'hFF, -1, -1);
    chk("ff_end_busy", 32'(busy), 32'(0));

    // Strobe while busy is dropped
    frame(8'h81, 10, -1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drop_idle_tx_%0d", i), 32'(tx), 32'(1));
      chk($sformatf("drop_idle_busy_%0d", i), 32'(busy), 32'(0));
      step();
    end

    // Blocked: strobe is ignored
    block = 1'b1;
    step();
    step();
    chk("blk_busy", 32'(busy), 32'(1));
    data = 8'h55;
    new_data = 1'b1;
    step();
    new_data = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("blk_tx_%0d", i), 32'(tx), 32'(1));
      chk($sformatf("blk_busy_%0d", i), 32'(busy), 32'(1));
      step();
    end
    block = 1'b0;
    step();
    step();
    chk("unblk_busy", 32'(busy), 32'(0));

    // Block raised at data bit 3 of an in-flight frame
    frame(8'hC3, -1, 4 * CPB);
    chk("blk_after_busy", 32'(busy), 32'(1));
    chk("blk_after_tx", 32'(tx), 32'(1));
    block = 1'b0;
    step();
    step();
    chk("blk_release_busy", 32'(busy), 32'(0));

    // Reset during data bit 4
    bits96 = {1'b1, 8'h96, 1'b0};
    data = 8'h96;
    new_data = 1'b1;
    step();
    new_data = 1'b0;
    for (int k = 0; k < 22; k++) begin
      chk($sformatf("tx_96_k%0d", k), 32'(tx), 32'(bits96[k / CPB]));
      step();
    end
    rst = 1'b1;
    step();
    chk("midrst_tx", 32'(tx), 32'(1));
    chk("midrst_busy", 32'(busy), 32'(1));
    chk("midrst_state", 32'(dut.state_q), 32'(0));
    rst = 1'b0;
    step();
    step();
    chk("midrst_release_busy", 32'(busy), 32'(0));
    frame(8'h12, -1, -1);
    chk("12_end_busy", 32'(busy), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- UART transmitter, 8N1 framing, LSB first. Pairs with the board's serial receiver on the same link, using the same CLK_PER_BIT bit timing.
- Accepts one byte per new_data pulse from the controller logic and serialises it onto tx.
- Exposes busy for flow control. Accepts a block input so the host side can pause transmission between frames.

Parameters:
- CLK_PER_BIT, 25, clk cycles per serial bit; must be >= 2.
- CTR_SIZE, $clog2(CLK_PER_BIT), bit-period counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- block  input  1  1 = do not start a new frame; asynchronous to frame timing, registered internally.
- data  input  8  byte to send; sampled only on an accepted new_data.
- new_data  input  1  single-cycle strobe; accepted only when busy = 0 in the same cycle.
- busy  output  1  1 = new_data will be ignored this cycle.
- tx  output  1  serial line; idles high; registered output.

Behaviour:
- Reset values:
  - tx = 1, busy = 1 (block_q resets to 1).
  - state = IDLE, bit counter = 0, bit index = 0, shift register = 0.
  - block_q loads block each cycle after reset.
- block_q is block registered once. busy = (state != IDLE) | block_q.
- States:
  - IDLE:
    - tx_d = 1.
    - If new_data & ~busy: capture data into the shift register, clear the counter, go to START_BIT.
  - START_BIT:
    - tx_d = 0; counter increments.
    - At counter == CLK_PER_BIT-1: clear the counter, bit index = 0, go to DATA.
  - DATA:
    - tx_d = shift[0]; counter increments.
    - At counter == CLK_PER_BIT-1: shift right, bit index +1, clear the counter.
    - If bit index == 7, go to STOP_BIT.
  - STOP_BIT:
    - tx_d = 1; counter increments.
    - At counter == CLK_PER_BIT-1: go to IDLE.
- Timing:
  - tx is registered, so the first start-bit cycle on tx is the cycle after acceptance.
  - Each bit is held exactly CLK_PER_BIT cycles; a frame is 10*CLK_PER_BIT cycles.
  - busy rises the cycle after acceptance and falls in the cycle where tx has shown 1 (stop) for CLK_PER_BIT cycles.
  - Back-to-back: new_data asserted in the first cycle busy = 0 produces the next start bit with no extra idle gap. Stop bit length is exactly CLK_PER_BIT.
- new_data with busy = 1 is dropped silently. No queueing; data is not latched.
- block asserted mid-frame does not abort or stretch the frame; it only prevents the next start.
- block and new_data in the same cycle: the decision uses block_q (previous-cycle value), consistent with busy as seen by the sender.
- Default/illegal state → IDLE, tx = 1.
- rst mid-frame: tx = 1 on the next cycle and the state returns to IDLE. The partial byte is discarded, never resumed.
- Counter width: CTR_SIZE bits; compare against CLK_PER_BIT-1 at CTR_SIZE width. No wrap is possible because the compare always fires first.

Decomposition:
- Shared package/include:
  - state encodings IDLE = 2'd0, START_BIT = 2'd1, DATA = 2'd2, STOP_BIT = 2'd3, STATE_SIZE = 2;
  - DATA_BITS = 8.
  - The serial receiver's state constants may move into the same package under distinct names.
- Single module, no sub-modules.
- Two always blocks: combinational next-state (_d) and registered (_q).

Test Plan:
- Reset: CLK_PER_BIT = 4, hold rst 3 cycles with block = 0 → tx = 1 throughout; busy = 1 during reset, 0 two cycles after release.
- Single byte: data = 8'hA5, pulse new_data → tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total); busy high for exactly 40 cycles; a loopback serial receiver reports 8'hA5.
- Back-to-back: send 8'h00 then 8'hFF on the first busy = 0 cycle → no idle gap between stop and the second start; both bytes received intact.
- Drop while busy: pulse new_data with 8'h3C mid-frame of 8'h81 → only 8'h81 is transmitted; 8'h3C never appears.
- Flow control: block = 1, pulse new_data 8'h55 → tx stays 1, busy = 1. Raise block at bit 3 of an in-flight frame → frame completes unchanged.
- Reset mid-frame: assert rst during DATA bit 4 → tx = 1 next cycle, state IDLE. A new 8'h12 after release is sent correctly.
